led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Sequences an LED blinker through a programmable table of (period, duration) steps.
- Drives the blinker's period input and its active-high reset. Each new period is loaded by a one-cycle reset pulse, and the LED is held off while the sequencer is idle.
- Sits between a CPU/config port and the blinker instance in the bring-up top level.

Parameters:
NUM_STEPS, 8, number of table entries (2..16)
DUR_W, 16, width of per-step duration field, in clk cycles
MIN_PERIOD, 1, smallest legal nonzero period; must match the blinker instance
MAX_PERIOD, 1000, largest legal period; must match the blinker instance
IDX_W, $clog2(NUM_STEPS), table index width (derived, do not override)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
cfg_we  input  1  table write strobe
cfg_idx  input  IDX_W  entry to write
cfg_period  input  32  blink period for entry; 0 = blinker default
cfg_duration  input  DUR_W  step length in clk cycles; 0 treated as 1
cfg_last  input  1  entry terminates the sequence
cfg_err  output  1  one-cycle pulse: write rejected
start  input  1  begin sequence at entry 0
stop  input  1  abort sequence
blink_period  output  32  to blinker period input
blink_rst  output  1  to blinker reset (active high)
busy  output  1  high in LOAD or RUN
step_idx  output  IDX_W  entry currently playing
done  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset (reset==0 at posedge clk):
  - state IDLE; all entries set to period=0, duration=0, last=0.
  - Outputs: blink_period=0, blink_rst=1, busy=0, step_idx=0, done=0, cfg_err=0.
  - Reset mid-sequence aborts immediately; no done pulse.
- Table write (registered, applied at posedge):
  - Accepted only in IDLE and only with period==0 or MIN_PERIOD<=period<=MAX_PERIOD.
  - Otherwise the entry is unchanged and cfg_err pulses high the following cycle.
  - A write while busy is always rejected.
- State IDLE:
  - blink_rst=1 (LED held off), busy=0.
  - start==1 && stop==0 -> LOAD with idx=0.
- State LOAD (exactly 1 cycle):
  - blink_period=entry[idx].period, blink_rst=1, step_idx=idx, busy=1.
  - Next state RUN with cnt=0.
- State RUN:
  - blink_rst=0; blink_period held.
  - D = max(entry[idx].duration, 1); cnt increments each cycle.
  - When cnt==D-1:
    - If entry[idx].last==1 or idx==NUM_STEPS-1: finish.
    - Else idx=idx+1 -> LOAD.
- Step timing: each step occupies exactly D+1 cycles (1 LOAD + D RUN). The blinker counts from zero at the first RUN cycle.
- Finish: next state IDLE, done=1 for that one cycle, blink_period keeps its last value, blink_rst=1.
- stop in LOAD or RUN: next cycle IDLE, no done pulse.
- stop and start in the same cycle: stop wins.
- start while busy: ignored.
- Counter width is DUR_W; duration=2^DUR_W-1 must not overflow or wrap early.
- step_idx wraps only via the optional feature; never exceeds NUM_STEPS-1.

Optional Feature:
SEQ_LOOP_EN
- Defined: at the finish point, the sequencer goes to LOAD with idx=0 instead of IDLE.
  - done pulses for one cycle in that LOAD cycle, once per wrap.
  - Runs until stop or reset.
- Undefined: sequence runs once, then returns to IDLE as described above.

Test Plan:
- Reset then idle 10 cycles -> blink_rst=1, blink_period=0, busy=0, done=0 throughout.
- Write entry0={period 5, dur 20, last 0} and entry1={period 2, dur 4, last 1}, then start at cycle T:
  - blink_rst pulses at T+1 with period 5.
  - blink_rst pulses at T+22 with period 2.
  - done at T+27; busy high for T+1..T+26.
- Write period 1001 to entry3 -> cfg_err pulses once and entry3 reads back unchanged via a run. Write period 0 -> accepted.
- Start with the 2-step table, assert stop at T+10 -> IDLE at T+11, blink_rst=1, no done; a write at T+5 is rejected with cfg_err.
- All 8 entries last=0, dur=1 -> sequence ends after entry 7; done at T+17.
- With SEQ_LOOP_EN, same table:
  - done pulses every 16 cycles and step_idx wraps 7->0.
  - stop ends the sequence.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - steps an LED blinker through a programmable (period, duration) table
// Optional feature macro SEQ_LOOP_EN: wrap from the final step back to entry 0 instead of returning to idle.
module led_pattern_sequencer #(
  parameter int  NUM_STEPS  = 8,
  parameter int  DUR_W      = 16,
  parameter int  MIN_PERIOD = 1,
  parameter int  MAX_PERIOD = 1000,
  localparam int IDX_W      = $clog2(NUM_STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_period,
  input  logic [DUR_W-1:0] cfg_duration,
  input  logic             cfg_last,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic [31:0]      blink_period,
  output logic             blink_rst,
  output logic             busy,
  output logic [IDX_W-1:0] step_idx,
  output logic             done
);

  localparam logic [31:0]      MIN_P    = 32'(MIN_PERIOD);
  localparam logic [31:0]      MAX_P    = 32'(MAX_PERIOD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [DUR_W-1:0] cnt_q;
  logic [31:0]      blink_period_q;
  logic             blink_rst_q;
  logic             busy_q;
  logic             done_q;
  logic             cfg_err_q;

  logic [31:0]      period_tab_q [NUM_STEPS];
  logic [DUR_W-1:0] dur_tab_q    [NUM_STEPS];
  logic             last_tab_q   [NUM_STEPS];

  logic             idx_ok;
  logic             period_ok;
  logic             wr_ok;
  logic [DUR_W-1:0] cnt_last;
  logic             step_end;
  logic             seq_end;
  logic [IDX_W-1:0] idx_d;

  // Only a non-power-of-two table can be addressed past its end.
  if (NUM_STEPS == (1 << IDX_W)) begin : g_full_idx
    assign idx_ok = 1'b1;
  end else begin : g_part_idx
    assign idx_ok = (cfg_idx <= LAST_IDX);
  end

  always_comb begin
    period_ok = (cfg_period == '0) || ((cfg_period >= MIN_P) && (cfg_period <= MAX_P));
    wr_ok     = cfg_we && (state_q == S_IDLE) && period_ok && idx_ok;
    // A zero duration plays as one cycle; computing D-1 this way never wraps.
    cnt_last  = (dur_tab_q[idx_q] == '0) ? '0 : dur_tab_q[idx_q] - DUR_W'(1);
    step_end  = (state_q == S_RUN) && (cnt_q == cnt_last);
    seq_end   = last_tab_q[idx_q] || (idx_q == LAST_IDX);
    idx_d     = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      blink_period_q <= '0;
      blink_rst_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        period_tab_q[i] <= '0;
        dur_tab_q[i]    <= '0;
        last_tab_q[i]   <= 1'b0;
      end
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= cfg_we && !wr_ok;

      if (wr_ok) begin
        period_tab_q[cfg_idx] <= cfg_period;
        dur_tab_q[cfg_idx]    <= cfg_duration;
        last_tab_q[cfg_idx]   <= cfg_last;
      end

      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q        <= S_LOAD;
            idx_q          <= '0;
            blink_period_q <= period_tab_q[0];
            blink_rst_q    <= 1'b1;
            busy_q         <= 1'b1;
          end
        end

        S_LOAD: begin
          if (stop) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            blink_rst_q <= 1'b1;
          end else begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            blink_rst_q <= 1'b0;
          end
        end

        S_RUN: begin
          if (stop) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            blink_rst_q <= 1'b1;
          end else if (step_end) begin
            blink_rst_q <= 1'b1;
            if (seq_end) begin
              done_q <= 1'b1;
`ifdef SEQ_LOOP_EN
              state_q        <= S_LOAD;
              idx_q          <= '0;
              blink_period_q <= period_tab_q[0];
`else
              // blink_period keeps the final step's value while idle.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              state_q        <= S_LOAD;
              idx_q          <= idx_d;
              blink_period_q <= period_tab_q[idx_d];
            end
          end else begin
            cnt_q <= cnt_q + DUR_W'(1);
          end
        end

        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          blink_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_err      = cfg_err_q;
  assign blink_period = blink_period_q;
  assign blink_rst    = blink_rst_q;
  assign busy         = busy_q;
  assign step_idx     = idx_q;
  assign done         = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer against a step-level model
module tb_led_pattern_sequencer;

  localparam int NUM_STEPS  = 8;
  localparam int DUR_W      = 16;
  localparam int MIN_PERIOD = 1;
  localparam int MAX_PERIOD = 1000;
  localparam int IDX_W      = $clog2(NUM_STEPS);
  localparam int NEVER      = 2147483647;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [31:0]      cfg_period;
  logic [DUR_W-1:0] cfg_duration;
  logic             cfg_last;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic [31:0]      blink_period;
  logic             blink_rst;
  logic             busy;
  logic [IDX_W-1:0] step_idx;
  logic             done;

  led_pattern_sequencer #(
    .NUM_STEPS (NUM_STEPS),
    .DUR_W     (DUR_W),
    .MIN_PERIOD(MIN_PERIOD),
    .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_period  (cfg_period),
    .cfg_duration(cfg_duration),
    .cfg_last    (cfg_last),
    .cfg_err     (cfg_err),
    .start       (start),
    .stop        (stop),
    .blink_period(blink_period),
    .blink_rst   (blink_rst),
    .busy        (busy),
    .step_idx    (step_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] period;
    int          idx;
  } load_ev_t;

  load_ev_t    load_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [31:0] m_period[NUM_STEPS];
  int          m_dur[NUM_STEPS];
  bit          m_last[NUM_STEPS];
  int          exp_busy_start = 1;
  int          exp_busy_end = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [31:0] cur_period = '0;
  int          cur_idx = 0;
  load_ev_t    ev_m;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_idle(input int c);
    return !((c >= exp_busy_start) && (c <= exp_busy_end));
  endfunction

  function automatic int horizon();
`ifdef SEQ_LOOP_EN
    return 400;
`else
    return 1000000;
`endif
  endfunction

  // Expected step schedule: each step is one LOAD cycle followed by max(dur,1) RUN cycles.
  task automatic gen_seq(input int t_start, input int limit);
    int t;
    int idx;
    int d;
    load_ev_t ev;
    t = t_start + 1;
    idx = 0;
    exp_busy_start = t_start + 1;
    exp_busy_end = NEVER;
    while (t <= limit) begin
      ev.cyc = t;
      ev.period = m_period[idx];
      ev.idx = idx;
      load_q.push_back(ev);
      d = (m_dur[idx] == 0) ? 1 : m_dur[idx];
      t = t + d + 1;
      if (m_last[idx] || idx == NUM_STEPS - 1) begin
        if (t <= limit) done_q.push_back(t);
`ifdef SEQ_LOOP_EN
        idx = 0;
`else
        exp_busy_end = t - 1;
        break;
`endif
      end else begin
        idx++;
      end
    end
  endtask

  task automatic truncate(input int s);
    load_ev_t lq[$];
    int dq[$];
    foreach (load_q[i]) if (load_q[i].cyc <= s) lq.push_back(load_q[i]);
    foreach (done_q[i]) if (done_q[i] <= s) dq.push_back(done_q[i]);
    load_q = lq;
    done_q = dq;
    if (exp_busy_end > s) exp_busy_end = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    truncate(cyc);
    for (int i = 0; i < NUM_STEPS; i++) begin
      m_period[i] = '0;
      m_dur[i] = 0;
      m_last[i] = 1'b0;
    end
    repeat (n) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input int idx, input logic [31:0] p, input int d, input bit l);
    bit legal;
    cfg_we = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_period = p;
    cfg_duration = DUR_W'(d);
    cfg_last = l;
    legal = (p == 0) || ((p >= MIN_PERIOD) && (p <= MAX_PERIOD));
    if (legal && model_idle(cyc)) begin
      m_period[idx] = p;
      m_dur[idx] = d;
      m_last[idx] = l;
    end else begin
      err_q.push_back(cyc + 1);
    end
    next_cycle();
  endtask

  task automatic do_start(input int hz);
    start = 1'b1;
    if (model_idle(cyc)) gen_seq(cyc, cyc + hz);
    next_cycle();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    truncate(cyc);
    next_cycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((load_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0 || cyc <= exp_busy_end) && n < 5000) begin
      next_cycle();
      n++;
    end
    chk_eq("drain_pending", load_q.size() + done_q.size() + err_q.size(), 0);
    next_cycle();
    next_cycle();
  endtask

  task automatic run_seq();
    do_start(horizon());
`ifdef SEQ_LOOP_EN
    if (done_q.size() > 0) wait_to(done_q[0]);
    do_stop();
`endif
    drain();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg_err) begin
        chk_eq("err_expected", err_q.size() > 0, 1);
        if (err_q.size() > 0) chk_eq("err_cycle", cyc, err_q.pop_front());
      end
      if (done) begin
        chk_eq("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) chk_eq("done_cycle", cyc, done_q.pop_front());
`ifdef SEQ_LOOP_EN
        chk_eq("done_wrap_idx", step_idx, 0);
`else
        chk_eq("done_busy", busy, 0);
        chk_eq("done_hold_period", blink_period, cur_period);
`endif
      end
      if (busy && blink_rst) begin
        chk_eq("load_expected", load_q.size() > 0, 1);
        if (load_q.size() > 0) begin
          ev_m = load_q.pop_front();
          chk_eq("load_cycle", cyc, ev_m.cyc);
          chk_eq("load_period", blink_period, ev_m.period);
          chk_eq("load_idx", step_idx, ev_m.idx);
          cur_period = ev_m.period;
          cur_idx = ev_m.idx;
        end
      end else if (busy) begin
        chk_eq("run_period", blink_period, cur_period);
        chk_eq("run_idx", step_idx, cur_idx);
      end
      chk_eq("busy", busy, (cyc >= exp_busy_start) && (cyc <= exp_busy_end));
      if (!busy) chk_eq("idle_blink_rst", blink_rst, 1);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int end_c;
    int s;
    logic [31:0] p;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_period = '0;
    cfg_duration = '0;
    cfg_last = 1'b0;
    start = 1'b0;
    stop = 1'b0;

    do_reset(3);
    mon_en = 1'b1;
    chk_eq("rst_blink_rst", blink_rst, 1);
    chk_eq("rst_blink_period", blink_period, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_step_idx", step_idx, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_cfg_err", cfg_err, 0);
    repeat (10) begin
      next_cycle();
      chk_eq("idle_period", blink_period, 0);
      chk_eq("idle_done", done, 0);
    end

    // Two-step table from the bring-up plan.
    do_write(0, 5, 20, 0);
    do_write(1, 2, 4, 1);
    next_cycle();
    run_seq();

    // Range limits, rejected writes leave the entry intact.
    do_write(1, 2, 4, 0);
    do_write(2, 3, 2, 0);
    do_write(3, 7, 3, 1);
    do_write(3, 1001, 9, 0);
    do_write(3, 32'hFFFF_FFFF, 9, 0);
    run_seq();
    do_write(3, 0, 0, 1);
    do_write(2, MAX_PERIOD, 1, 0);
    do_write(1, MIN_PERIOD, 0, 0);
    run_seq();

    // Stop mid-run with a rejected write while busy.
    do_write(1, 2, 4, 1);
    t0 = cyc;
    do_start(horizon());
    wait_to(t0 + 5);
    do_write(0, 9, 9, 0);
    wait_to(t0 + 10);
    do_stop();
    drain();

    // start and stop together while idle: nothing happens.
    start = 1'b1;
    stop = 1'b1;
    next_cycle();
    repeat (3) next_cycle();

    // All entries non-last with duration 1: runs off the end of the table.
    for (int i = 0; i < NUM_STEPS; i++) do_write(i, i + 1, 1, 0);
    run_seq();
`ifdef SEQ_LOOP_EN
    t0 = cyc;
    do_start(60);
    wait_to(t0 + 50);
    do_stop();
    drain();
`endif

    // Reset mid-sequence clears the table and aborts without done.
    t0 = cyc;
    do_start(horizon());
    wait_to(t0 + 6);
    do_reset(2);
    next_cycle();
    run_seq();

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        if ($urandom % 5 == 0) p = ($urandom % 2 == 0) ? 32'hFFFF_FFFF : $urandom_range(5000, MAX_PERIOD + 1);
        else p = $urandom_range(MAX_PERIOD, 0);
        do_write(i, p, ($urandom % 6 == 0) ? int'($urandom_range(40, 13)) : int'($urandom_range(12, 0)),
                 ($urandom % 6 == 0));
      end
      t0 = cyc;
      do_start(horizon());
      if ($urandom % 2 == 0) do_write($urandom_range(NUM_STEPS - 1, 0), $urandom_range(MAX_PERIOD, 0), 3, 1'b0);
      else do_start(horizon());
`ifdef SEQ_LOOP_EN
      end_c = (done_q.size() > 0) ? done_q[0] : t0 + 300;
      s = $urandom_range(end_c, t0 + 2);
      wait_to(s);
      do_stop();
`else
      end_c = exp_busy_end;
      if ($urandom % 3 == 0) begin
        s = $urandom_range(end_c, t0 + 2);
        wait_to(s);
        do_stop();
      end
`endif
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
